// File: rtl/ac97_frame_sched.sv
// AC-link per-frame scheduler: codec init writes, host register access on slots 1/2, PCM on slots 3/4.
// Optional read timeout: define AC97_READ_TIMEOUT_EN.
module ac97_frame_sched #(
  parameter int RESET_WAIT_FRAMES = 4,
  parameter int TIMEOUT_FRAMES    = 16
) (
  input  logic        ac97_bitclk,
  input  logic        rst_b,
  input  logic        ac97_strobe,
  input  logic        ac97_in_codec_ready,
  input  logic [19:0] ac97_in_slot1,
  input  logic        ac97_in_slot1_valid,
  input  logic [19:0] ac97_in_slot2,
  output logic [19:0] ac97_out_slot1,
  output logic        ac97_out_slot1_valid,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot2_valid,
  output logic [19:0] ac97_out_slot3,
  output logic        ac97_out_slot3_valid,
  output logic [19:0] ac97_out_slot4,
  output logic        ac97_out_slot4_valid,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  input  logic        pcm_valid,
  input  logic [19:0] pcm_left,
  input  logic [19:0] pcm_right,
  output logic        pcm_ready,
  output logic        init_done,
  output logic [15:0] underrun_cnt
);

  localparam int WAIT_W = $clog2(RESET_WAIT_FRAMES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_CMD_WR  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  state_t              state_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [1:0]          init_idx_r;
  logic [6:0]          req_idx_r;
  logic [19:0]         slot1_r, slot2_r, slot3_r, slot4_r;
  logic                slot1_v_r, slot2_v_r, slot3_v_r, slot4_v_r;
  logic                host_ack_r, host_err_r, init_done_r;
  logic [15:0]         host_rdata_r, underrun_r;
  logic [22:0]         init_entry_s;
  logic                rd_match_s;
  logic                unused_s;

  // Init table entry as {register index, write data}.
  function automatic logic [22:0] init_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    init_entry = {7'h02, 16'h0000};
      2'd1:    init_entry = {7'h04, 16'h0000};
      2'd2:    init_entry = {7'h18, 16'h0808};
      default: init_entry = 23'h000000;
    endcase
  endfunction

  assign init_entry_s = init_entry(init_idx_r);
  assign rd_match_s   = ac97_in_slot1_valid && (ac97_in_slot1[18:12] == req_idx_r);
  assign unused_s     = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

`ifdef AC97_READ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_r;
`else
  logic [TO_W-1:0] unused_to_s;
  assign unused_to_s = '0;
`endif

  // Control FSM: command slots 1/2 and host handshake, updated on frame edges only.
  always_ff @(posedge ac97_bitclk or negedge rst_b) begin
    if (!rst_b) begin
      state_r      <= ST_WAIT;
      wait_cnt_r   <= '0;
      init_idx_r   <= 2'd0;
      req_idx_r    <= 7'h00;
      slot1_r      <= 20'h00000;
      slot1_v_r    <= 1'b0;
      slot2_r      <= 20'h00000;
      slot2_v_r    <= 1'b0;
      host_ack_r   <= 1'b0;
      host_err_r   <= 1'b0;
      host_rdata_r <= 16'h0000;
      init_done_r  <= 1'b0;
`ifdef AC97_READ_TIMEOUT_EN
      to_cnt_r     <= '0;
`endif
    end else begin
      host_ack_r <= 1'b0;
      if (ac97_strobe) begin
        case (state_r)
          ST_WAIT: begin
            if (wait_cnt_r == WAIT_W'(RESET_WAIT_FRAMES - 1)) begin
              if (ac97_in_codec_ready) begin
                slot1_r    <= {1'b0, init_entry_s[22:16], 12'h000};
                slot1_v_r  <= 1'b1;
                slot2_r    <= {init_entry_s[15:0], 4'h0};
                slot2_v_r  <= 1'b1;
                init_idx_r <= 2'd1;
                state_r    <= ST_INIT;
              end
            end else begin
              wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
          end
          ST_INIT: begin
            if (init_idx_r == 2'd3) begin
              slot1_r     <= 20'h00000;
              slot1_v_r   <= 1'b0;
              slot2_r     <= 20'h00000;
              slot2_v_r   <= 1'b0;
              init_done_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              slot1_r    <= {1'b0, init_entry_s[22:16], 12'h000};
              slot1_v_r  <= 1'b1;
              slot2_r    <= {init_entry_s[15:0], 4'h0};
              slot2_v_r  <= 1'b1;
              init_idx_r <= init_idx_r + 2'd1;
            end
          end
          ST_IDLE: begin
            if (host_req) begin
              req_idx_r <= host_addr;
              slot1_r   <= {~host_wr, host_addr, 12'h000};
              slot1_v_r <= 1'b1;
`ifdef AC97_READ_TIMEOUT_EN
              to_cnt_r  <= '0;
`endif
              if (host_wr) begin
                slot2_r   <= {host_wdata, 4'h0};
                slot2_v_r <= 1'b1;
                state_r   <= ST_CMD_WR;
              end else begin
                slot2_r   <= 20'h00000;
                slot2_v_r <= 1'b0;
                state_r   <= ST_RD_WAIT;
              end
            end
          end
          ST_CMD_WR: begin
            slot1_r    <= 20'h00000;
            slot1_v_r  <= 1'b0;
            slot2_r    <= 20'h00000;
            slot2_v_r  <= 1'b0;
            host_ack_r <= 1'b1;
            host_err_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
          ST_RD_WAIT: begin
            slot1_r   <= 20'h00000;
            slot1_v_r <= 1'b0;
            if (rd_match_s) begin
              host_rdata_r <= ac97_in_slot2[19:4];
              host_ack_r   <= 1'b1;
              host_err_r   <= 1'b0;
              state_r      <= ST_IDLE;
`ifdef AC97_READ_TIMEOUT_EN
            end else if (to_cnt_r == TO_W'(TIMEOUT_FRAMES - 1)) begin
              host_rdata_r <= 16'hFFFF;
              host_ack_r   <= 1'b1;
              host_err_r   <= 1'b1;
              state_r      <= ST_IDLE;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
`endif
            end
          end
          default: state_r <= ST_WAIT;
        endcase
      end
    end
  end

  // PCM slots 3/4 and underrun counting; samples only flow once init is complete.
  always_ff @(posedge ac97_bitclk or negedge rst_b) begin
    if (!rst_b) begin
      slot3_r    <= 20'h00000;
      slot3_v_r  <= 1'b0;
      slot4_r    <= 20'h00000;
      slot4_v_r  <= 1'b0;
      underrun_r <= 16'h0000;
    end else if (ac97_strobe) begin
      if (init_done_r && pcm_valid) begin
        slot3_r   <= pcm_left;
        slot3_v_r <= 1'b1;
        slot4_r   <= pcm_right;
        slot4_v_r <= 1'b1;
      end else begin
        slot3_r   <= 20'h00000;
        slot3_v_r <= 1'b0;
        slot4_r   <= 20'h00000;
        slot4_v_r <= 1'b0;
        if (init_done_r && (underrun_r != 16'hFFFF)) begin
          underrun_r <= underrun_r + 16'd1;
        end
      end
    end
  end

  assign pcm_ready            = ac97_strobe && init_done_r;
  assign ac97_out_slot1       = slot1_r;
  assign ac97_out_slot1_valid = slot1_v_r;
  assign ac97_out_slot2       = slot2_r;
  assign ac97_out_slot2_valid = slot2_v_r;
  assign ac97_out_slot3       = slot3_r;
  assign ac97_out_slot3_valid = slot3_v_r;
  assign ac97_out_slot4       = slot4_r;
  assign ac97_out_slot4_valid = slot4_v_r;
  assign host_ack             = host_ack_r;
  assign host_rdata           = host_rdata_r;
  assign host_err             = host_err_r;
  assign init_done            = init_done_r;
  assign underrun_cnt         = underrun_r;

endmodule

// File: tb/tb_ac97_frame_sched.sv
// Bench for ac97_frame_sched: frame-level reference model compared every cycle, plus directed literal checks.
module tb_ac97_frame_sched;

  localparam int FRAME      = 8;
  localparam int RESET_WAIT = 4;
  localparam int TIMEOUT    = 16;

  logic        ac97_bitclk = 1'b0;
  logic        rst_b = 1'b0;
  logic        ac97_strobe = 1'b0;
  logic        ac97_in_codec_ready = 1'b1;
  logic [19:0] ac97_in_slot1 = 20'h0;
  logic        ac97_in_slot1_valid = 1'b0;
  logic [19:0] ac97_in_slot2 = 20'h0;
  logic [19:0] ac97_out_slot1, ac97_out_slot2, ac97_out_slot3, ac97_out_slot4;
  logic        ac97_out_slot1_valid, ac97_out_slot2_valid, ac97_out_slot3_valid, ac97_out_slot4_valid;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [6:0]  host_addr = 7'h0;
  logic [15:0] host_wdata = 16'h0;
  logic        host_ack, host_err, pcm_ready, init_done;
  logic [15:0] host_rdata, underrun_cnt;
  logic        pcm_valid = 1'b0;
  logic [19:0] pcm_left = 20'h0;
  logic [19:0] pcm_right = 20'h0;

  ac97_frame_sched dut (
    .ac97_bitclk(ac97_bitclk), .rst_b(rst_b), .ac97_strobe(ac97_strobe),
    .ac97_in_codec_ready(ac97_in_codec_ready), .ac97_in_slot1(ac97_in_slot1),
    .ac97_in_slot1_valid(ac97_in_slot1_valid), .ac97_in_slot2(ac97_in_slot2),
    .ac97_out_slot1(ac97_out_slot1), .ac97_out_slot1_valid(ac97_out_slot1_valid),
    .ac97_out_slot2(ac97_out_slot2), .ac97_out_slot2_valid(ac97_out_slot2_valid),
    .ac97_out_slot3(ac97_out_slot3), .ac97_out_slot3_valid(ac97_out_slot3_valid),
    .ac97_out_slot4(ac97_out_slot4), .ac97_out_slot4_valid(ac97_out_slot4_valid),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .pcm_valid(pcm_valid), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .pcm_ready(pcm_ready), .init_done(init_done), .underrun_cnt(underrun_cnt)
  );

  always #5 ac97_bitclk = ~ac97_bitclk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Link strobe: one cycle in every FRAME, free-running through reset.
  initial forever begin
    @(posedge ac97_bitclk);
    #2;
    ac97_strobe = (strobe_cnt == FRAME - 1);
    strobe_cnt  = (strobe_cnt + 1) % FRAME;
  end

  // ---------------- frame-level reference model ----------------
  logic [19:0] tbl_s1 [3] = '{20'h02000, 20'h04000, 20'h18000};
  logic [19:0] tbl_s2 [3] = '{20'h00000, 20'h00000, 20'h08080};
  int          m_edge, m_init_start, m_op_edge;
  bit          m_busy, m_op_rd;
  logic [6:0]  m_op_idx;
  logic [19:0] m_s1, m_s2, m_s3, m_s4;
  logic        m_v1, m_v2, m_v3, m_v4, m_ack, m_err, m_done;
  logic [15:0] m_rdata, m_under;

  task automatic model_reset();
    m_edge = 0; m_init_start = -1; m_op_edge = 0; m_busy = 0; m_op_rd = 0; m_op_idx = 7'h0;
    m_s1 = 20'h0; m_s2 = 20'h0; m_s3 = 20'h0; m_s4 = 20'h0;
    m_v1 = 1'b0; m_v2 = 1'b0; m_v3 = 1'b0; m_v4 = 1'b0;
    m_ack = 1'b0; m_err = 1'b0; m_done = 1'b0; m_rdata = 16'h0; m_under = 16'h0;
  endtask

  task automatic model_frame();
    logic done_before;
    int   k;
    m_edge++;
    done_before = m_done;
    m_s1 = 20'h0; m_v1 = 1'b0; m_s2 = 20'h0; m_v2 = 1'b0;
    if (m_init_start < 0 && m_edge >= RESET_WAIT && ac97_in_codec_ready) m_init_start = m_edge;
    if (m_init_start >= 0) begin
      k = m_edge - m_init_start;
      if (k < 3) begin
        m_s1 = tbl_s1[k]; m_v1 = 1'b1; m_s2 = tbl_s2[k]; m_v2 = 1'b1;
      end
      if (k == 3) m_done = 1'b1;
    end
    if (m_busy) begin
      if (!m_op_rd) begin
        m_ack = 1'b1; m_err = 1'b0; m_busy = 0;
      end else if (ac97_in_slot1_valid && ac97_in_slot1[18:12] == m_op_idx) begin
        m_ack = 1'b1; m_err = 1'b0; m_rdata = ac97_in_slot2[19:4]; m_busy = 0;
`ifdef AC97_READ_TIMEOUT_EN
      end else if (m_edge - m_op_edge == TIMEOUT) begin
        m_ack = 1'b1; m_err = 1'b1; m_rdata = 16'hFFFF; m_busy = 0;
`endif
      end
    end else if (m_init_start >= 0 && m_edge > m_init_start + 3 && host_req) begin
      m_busy = 1; m_op_rd = !host_wr; m_op_edge = m_edge; m_op_idx = host_addr;
      m_s1 = (host_wr ? 20'h00000 : 20'h80000) | (20'(host_addr) << 12);
      m_v1 = 1'b1;
      if (host_wr) begin
        m_s2 = 20'(host_wdata) << 4; m_v2 = 1'b1;
      end
    end
    if (done_before && pcm_valid) begin
      m_s3 = pcm_left; m_v3 = 1'b1; m_s4 = pcm_right; m_v4 = 1'b1;
    end else begin
      m_s3 = 20'h0; m_v3 = 1'b0; m_s4 = 20'h0; m_v4 = 1'b0;
      if (done_before && m_under != 16'hFFFF) m_under = m_under + 16'd1;
    end
  endtask

  // Model update on every clock edge / reset assertion.
  initial begin
    model_reset();
    forever begin
      @(posedge ac97_bitclk or negedge rst_b);
      if (!rst_b) model_reset();
      else begin
        m_ack = 1'b0;
        if (ac97_strobe) model_frame();
      end
    end
  end

  // Compare DUT against the model every cycle, half a clock after the active edge.
  initial forever begin
    @(negedge ac97_bitclk);
    chk("cmd_slots", {ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid},
                     {m_s1, m_v1, m_s2, m_v2});
    chk("pcm_slots", {ac97_out_slot3, ac97_out_slot3_valid, ac97_out_slot4, ac97_out_slot4_valid},
                     {m_s3, m_v3, m_s4, m_v4});
    chk("host_resp", {host_ack, host_err, host_rdata}, {m_ack, m_err, m_rdata});
    chk("status",    {init_done, underrun_cnt, pcm_ready}, {m_done, m_under, ac97_strobe && m_done});
  end

  // ---------------- directed stimulus ----------------
  task automatic frame();
    @(posedge ac97_bitclk);
    while (!ac97_strobe) @(posedge ac97_bitclk);
    #1;
  endtask

  task automatic wait_ack(input int max_frames, output int n, output bit got);
    got = 0; n = 0;
    while (!got && n < max_frames) begin
      frame();
      n++;
      if (host_ack) got = 1;
    end
  endtask

  int n_frames;
  bit got_ack;

  initial begin
    repeat (3) @(posedge ac97_bitclk);
    #1;
    chk("reset_outputs", {ac97_out_slot1_valid, ac97_out_slot3_valid, host_ack, init_done, underrun_cnt},
                         {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_b = 1'b1;

    // init sequence
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("wait_idle", ac97_out_slot1_valid, 1'b0);
    end
    frame();
    chk("init_w0", {ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid}, {20'h02000, 1'b1, 20'h00000, 1'b1});
    frame();
    chk("init_w1", {ac97_out_slot1, ac97_out_slot2}, {20'h04000, 20'h00000});
    frame();
    chk("init_w2", {ac97_out_slot1, ac97_out_slot2}, {20'h18000, 20'h08080});
    frame();
    chk("init_done", {init_done, ac97_out_slot1_valid, underrun_cnt}, {1'b1, 1'b0, 16'h0000});

    // host write with PCM flowing
    pcm_valid = 1'b1; pcm_left = 20'h12345; pcm_right = 20'hABCDE;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 7'h2C; host_wdata = 16'hBB80;
    frame();
    chk("wr_cmd", {ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid}, {20'h2C000, 1'b1, 20'hBB800, 1'b1});
    chk("pcm_load", {ac97_out_slot3, ac97_out_slot3_valid, ac97_out_slot4, ac97_out_slot4_valid}, {20'h12345, 1'b1, 20'hABCDE, 1'b1});
    frame();
    chk("wr_ack", {host_ack, host_err, ac97_out_slot1_valid}, {1'b1, 1'b0, 1'b0});
    host_req = 1'b0;

    // underrun for three frames
    pcm_valid = 1'b0;
    repeat (3) frame();
    chk("underrun3", {underrun_cnt, ac97_out_slot3_valid, ac97_out_slot3}, {16'd3, 1'b0, 20'h0});
    pcm_valid = 1'b1;
    frame();
    chk("pcm_resume", {underrun_cnt, ac97_out_slot3_valid}, {16'd3, 1'b1});

    // host read, wrong-index status first, match two frames after the command
    host_req = 1'b1; host_wr = 1'b0; host_addr = 7'h26;
    frame();
    chk("rd_cmd", {ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2_valid}, {20'hA6000, 1'b1, 1'b0});
    ac97_in_slot1 = 20'h2C000; ac97_in_slot1_valid = 1'b1; ac97_in_slot2 = 20'h12340;
    frame();
    chk("rd_nomatch", {host_ack, ac97_out_slot1_valid}, {1'b0, 1'b0});
    ac97_in_slot1 = 20'h26000; ac97_in_slot2 = 20'h000F0;
    frame();
    chk("rd_ack", {host_ack, host_err, host_rdata}, {1'b1, 1'b0, 16'h000F});
    host_req = 1'b0; ac97_in_slot1_valid = 1'b0;
    frame();

    // read with no status reply
    host_req = 1'b1; host_wr = 1'b0; host_addr = 7'h10;
    frame();
`ifdef AC97_READ_TIMEOUT_EN
    wait_ack(30, n_frames, got_ack);
    chk("to_frames", {got_ack, 32'(n_frames)}, {1'b1, 32'd16});
    chk("to_resp", {host_err, host_rdata}, {1'b1, 16'hFFFF});
    host_req = 1'b0;
`else
    wait_ack(20, n_frames, got_ack);
    chk("no_timeout", got_ack, 1'b0);
    ac97_in_slot1 = 20'h10000; ac97_in_slot1_valid = 1'b1; ac97_in_slot2 = 20'h55550;
    wait_ack(3, n_frames, got_ack);
    chk("late_match", {got_ack, host_err, host_rdata}, {1'b1, 1'b0, 16'h5555});
    host_req = 1'b0; ac97_in_slot1_valid = 1'b0;
`endif
    frame();

    // reset in the middle of a pending read
    host_req = 1'b1; host_wr = 1'b0; host_addr = 7'h30;
    frame();
    frame();
    @(posedge ac97_bitclk);
    #2;
    rst_b = 1'b0; host_req = 1'b0;
    #1;
    chk("midreset", {ac97_out_slot1_valid, ac97_out_slot3_valid, host_ack, host_rdata, init_done, underrun_cnt},
                    {1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
    repeat (3) @(posedge ac97_bitclk);
    #1;
    rst_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("rewait", {ac97_out_slot1_valid, host_ack, init_done}, {1'b0, 1'b0, 1'b0});
    end
    frame();
    chk("reinit_w0", {ac97_out_slot1, ac97_out_slot1_valid}, {20'h02000, 1'b1});
    repeat (3) frame();
    chk("reinit_done", {init_done, host_ack}, {1'b1, 1'b0});
    frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
